// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence generator/detector path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

    // FSM state encoding, shared by the generator and anything decoding its state
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SEND = 2'b01,
        S_GAP  = 2'b10,
        S_DONE = 2'b11
    } seq_state_t;

    // Default geometry of the generator
    localparam int DEF_PAT_W = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_CNT_W = 4;

    // Canonical detector pattern, also used by the detector benches
    localparam logic [2:0] SEQ_001     = 3'b001;
    localparam int         SEQ_001_LEN = 3;

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter with zero/one flags for the sequence generator.
// Latency: count updates one cycle after load/dec; flags follow count combinationally.
// Backpressure: none; load has priority over dec.
module seq_down_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         is_zero,
    output logic         is_one
);

    // Count register: load wins over decrement, holds otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - W'(1);
        end
    end

    assign is_zero = (count == '0);
    assign is_one  = (count == W'(1));

endmodule

// File: rtl/sequence_gen.sv
// Serial pattern transmitter: sends pattern[len-1:0] MSB-first reps times with gap idle bits.
// Latency: first bit on dout the cycle after start is sampled; done one cycle after the last bit.
// Backpressure: none; start is only sampled in IDLE and is dropped while busy.
module sequence_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] reps,
    input  logic [CNT_W-1:0] gap,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    seq_state_t       state;
    seq_state_t       nxt_state;

    // Transmission parameters captured at start
    logic [PAT_W-1:0] pat_reg;
    logic [LEN_W-1:0] len_reg;
    logic [CNT_W-1:0] gap_reg;

    // Counter controls and status
    logic             bit_load;
    logic             bit_dec;
    logic [LEN_W-1:0] bit_val;
    logic [LEN_W-1:0] bit_cnt;
    logic             bit_zero;
    logic             bit_one;

    logic             rep_load;
    logic             rep_dec;
    logic [CNT_W-1:0] rep_cnt;
    logic             rep_zero;
    logic             rep_one;

    logic             gap_load;
    logic             gap_dec;
    logic [CNT_W-1:0] gap_cnt;
    logic             gap_zero;
    logic             gap_one;

    logic             len_ok;
    logic             reps_ok;
    logic             accept;
    logic             nxt_bit;

    // Select one pattern bit by a LEN_W-wide index; out-of-range reads as idle level
    function automatic logic pick_bit(input logic [PAT_W-1:0] p,
                                      input logic [LEN_W-1:0] idx);
        logic b;
        b = 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
            if (idx == LEN_W'(i)) begin
                b = p[i];
            end
        end
        return b;
    endfunction

    // A request is only honoured with a length in 1..PAT_W and a non-zero repeat count
    assign len_ok  = (len != '0) && (len <= LEN_W'(PAT_W));
    assign reps_ok = (reps != '0);
    assign accept  = start && len_ok && reps_ok;

    // Bit index within the current repetition
    seq_down_cnt #(.W(LEN_W)) u_bit_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (bit_load),
        .dec      (bit_dec),
        .load_val (bit_val),
        .count    (bit_cnt),
        .is_zero  (bit_zero),
        .is_one   (bit_one)
    );

    // Repetitions remaining, including the one in progress
    seq_down_cnt #(.W(CNT_W)) u_rep_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (rep_load),
        .dec      (rep_dec),
        .load_val (reps),
        .count    (rep_cnt),
        .is_zero  (rep_zero),
        .is_one   (rep_one)
    );

    // Idle bits remaining in the current gap
    seq_down_cnt #(.W(CNT_W)) u_gap_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .dec      (gap_dec),
        .load_val (gap_reg),
        .count    (gap_cnt),
        .is_zero  (gap_zero),
        .is_one   (gap_one)
    );

    // Flags and counts that the sequencing does not need
    logic unused_ok;
    assign unused_ok = &{1'b0, bit_one, rep_cnt, rep_zero, gap_cnt, gap_zero};

    // Next-state, counter control and the bit to present next cycle
    always_comb begin
        nxt_state = state;
        bit_load  = 1'b0;
        bit_dec   = 1'b0;
        bit_val   = len_reg - LEN_W'(1);
        rep_load  = 1'b0;
        rep_dec   = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
        nxt_bit   = 1'b1;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    nxt_state = S_SEND;
                    bit_load  = 1'b1;
                    bit_val   = len - LEN_W'(1);
                    rep_load  = 1'b1;
                    nxt_bit   = pick_bit(pattern, len - LEN_W'(1));
                end
            end
            S_SEND: begin
                if (bit_zero) begin
                    if (rep_one) begin
                        nxt_state = S_DONE;
                    end else if (gap_reg == '0) begin
                        // Back-to-back repetition: restart at the MSB without leaving SEND
                        bit_load = 1'b1;
                        rep_dec  = 1'b1;
                        nxt_bit  = pick_bit(pat_reg, len_reg - LEN_W'(1));
                    end else begin
                        gap_load  = 1'b1;
                        rep_dec   = 1'b1;
                        nxt_state = S_GAP;
                    end
                end else begin
                    bit_dec = 1'b1;
                    nxt_bit = pick_bit(pat_reg, bit_cnt - LEN_W'(1));
                end
            end
            S_GAP: begin
                if (gap_one) begin
                    bit_load  = 1'b1;
                    nxt_state = S_SEND;
                    nxt_bit   = pick_bit(pat_reg, len_reg - LEN_W'(1));
                end else begin
                    gap_dec = 1'b1;
                end
            end
            S_DONE: begin
                nxt_state = S_IDLE;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // State, captured parameters and registered outputs derived from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pat_reg    <= '0;
            len_reg    <= '0;
            gap_reg    <= '0;
            dout       <= 1'b1;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= nxt_state;
            dout       <= (nxt_state == S_SEND) ? nxt_bit : 1'b1;
            dout_valid <= (nxt_state == S_SEND);
            busy       <= (nxt_state != S_IDLE);
            done       <= (nxt_state == S_DONE);
            if ((state == S_IDLE) && accept) begin
                pat_reg <= pattern;
                len_reg <= len;
                gap_reg <= gap;
            end
        end
    end

endmodule

// File: tb/tb_sequence_gen.sv
// Bench for sequence_gen: per-cycle expected outputs queued at start, popped by a monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_sequence_gen;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic [3:0] gap;
    logic       dout;
    logic       dout_valid;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    sequence_gen #(.PAT_W(8), .LEN_W(4), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pattern    (pattern),
        .len        (len),
        .reps       (reps),
        .gap        (gap),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    // Expected per-cycle tuple {dout_valid, dout, busy, done}
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;
    logic [3:0] mon_act;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    // Loopback 001 detector on the raw serial line
    logic [2:0] det_hist = 3'b111;
    int         det_fires = 0;

    // Monitor: every cycle compare outputs to the next queued tuple, or to idle if none
    always @(negedge clk) begin
        if (mon_en) begin
            mon_act = {dout_valid, dout, busy, done};
            if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
            else                  mon_exp = 4'b0100;
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL cycle_out t=%0t: got vld/dout/busy/done=%b required %b",
                         $time, mon_act, mon_exp);
            end
            det_hist = {det_hist[1:0], dout};
            if (det_hist == SEQ_001) det_fires++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Hand-written waveform table for one transmission, pushed when start is sampled
    task automatic expect_tx(input logic [7:0] p, input int l, input int r, input int g);
        logic [7:0] pv;
        pv = p;
        for (int ri = 0; ri < r; ri++) begin
            for (int b = l - 1; b >= 0; b--) exp_q.push_back({1'b1, pv[b], 1'b1, 1'b0});
            if (ri < r - 1)
                for (int gi = 0; gi < g; gi++) exp_q.push_back(4'b0110);
        end
        exp_q.push_back(4'b0111);
    endtask

    // Drive start for one sampling edge; returns in cycle T+1
    task automatic issue(input logic [7:0] p, input int l, input int r, input int g);
        pattern = p;
        len     = 4'(l);
        reps    = 4'(r);
        gap     = 4'(g);
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    // Wait (bounded) for done; n0 is the current cycle offset from the start edge
    task automatic wait_done(input string name, input int n0, input int req);
        int n;
        n = n0;
        while (!done && n < 300) begin
            step();
            n++;
        end
        check(name, n, req);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        gap     = '0;
        repeat (3) step();
        reset   = 1'b0;

        check("reset_dout", int'(dout), 1);
        check("reset_valid", int'(dout_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        mon_en = 1'b1;
        step();

        // 001, single repetition: bits T+1..T+3, done T+4, idle T+5
        issue(8'b0000_0001, 3, 1, 0);
        expect_tx(8'b0000_0001, 3, 1, 0);
        wait_done("done_001_r1", 1, 4);
        step();
        check("busy_after_001", int'(busy), 0);
        step();

        // 001, three repetitions with two idle bits between
        issue(8'b0000_0001, 3, 3, 2);
        expect_tx(8'b0000_0001, 3, 3, 2);
        wait_done("done_001_r3g2", 1, 14);
        repeat (2) step();

        // A5 twice back-to-back
        issue(8'hA5, 8, 2, 0);
        expect_tx(8'hA5, 8, 2, 0);
        wait_done("done_a5_r2", 1, 17);
        repeat (2) step();

        // Single-bit pattern, reload every cycle, with gap ignored for reps=1 later
        issue(8'b0000_0001, 1, 3, 0);
        expect_tx(8'b0000_0001, 1, 3, 0);
        wait_done("done_len1_r3", 1, 4);
        repeat (2) step();

        issue(8'b0000_0010, 2, 1, 7);
        expect_tx(8'b0000_0010, 2, 1, 7);
        wait_done("done_r1_gap_ignored", 1, 3);
        repeat (2) step();

        // Illegal requests: nothing queued, monitor expects idle throughout
        issue(8'hFF, 0, 2, 0);
        repeat (3) step();
        check("len0_busy", int'(busy), 0);
        issue(8'hFF, 3, 0, 0);
        repeat (3) step();
        check("reps0_busy", int'(busy), 0);
        issue(8'hFF, 9, 1, 0);
        repeat (3) step();
        check("len9_busy", int'(busy), 0);

        // Start during transmission is dropped
        issue(8'b0000_0001, 3, 3, 2);
        expect_tx(8'b0000_0001, 3, 3, 2);
        repeat (3) step();
        issue(8'hFF, 8, 1, 0);
        wait_done("done_mid_start", 5, 14);
        repeat (3) step();

        // Reset during the second SEND cycle aborts without done
        issue(8'b0000_0001, 3, 1, 0);
        exp_q.push_back(4'b1010);
        exp_q.push_back(4'b1010);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(dout_valid), 0);
        check("abort_dout", int'(dout), 1);
        check("abort_done", int'(done), 0);
        repeat (3) step();

        // Loopback into the 001 detector
        det_fires = 0;
        issue(8'b0000_0001, 3, 3, 2);
        expect_tx(8'b0000_0001, 3, 3, 2);
        wait_done("done_loopback", 1, 14);
        repeat (3) step();
        check("loopback_fires", det_fires, 3);

        begin
            int k;
            k = 0;
            while (exp_q.size() > 0 && k < 100) begin
                step();
                k++;
            end
            check("queue_drained", exp_q.size(), 0);
        end

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
